// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin sharing of one external add/sub ALU.
// clk/reset; req/op/a/b in; grant/done/result/busy out; alu_a/b/op out, alu_result in.
module alu_scheduler #(
    parameter int DATA_WIDTH = 11,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_in,
    input  logic [NUM_REQ-1:0]            op_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] a_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] b_in,
    output logic [NUM_REQ-1:0]            grant_out,
    output logic [NUM_REQ-1:0]            done_out,
    output logic [DATA_WIDTH-1:0]         result_out,
    output logic                          busy_out,
    output logic [DATA_WIDTH-1:0]         alu_a_out,
    output logic [DATA_WIDTH-1:0]         alu_b_out,
    output logic                          alu_op_out,
    input  logic [DATA_WIDTH-1:0]         alu_result_in
);

    localparam int IDX_WIDTH = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t state, state_next;

    logic [IDX_WIDTH-1:0]  last_idx;
    logic [IDX_WIDTH-1:0]  win;
    logic                  found;
    logic                  load;
    logic                  capture;
    logic [NUM_REQ-1:0]    grant_next;
    logic [NUM_REQ-1:0]    done_next;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic                  sel_op;

    function automatic logic [NUM_REQ-1:0] onehot(
        input logic [IDX_WIDTH-1:0] idx
    );
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Search starts just after the last winner and wraps,
    // so the previous winner has lowest priority.
    always_comb begin
        logic [IDX_WIDTH-1:0] j;
        j     = '0;
        found = 1'b0;
        win   = last_idx;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = IDX_WIDTH'((int'(last_idx) + k) % NUM_REQ);
            if (!found && req_in[j]) begin
                found = 1'b1;
                win   = j;
            end
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IDX_WIDTH'(i)) begin
                sel_a  = a_in[i*DATA_WIDTH +: DATA_WIDTH];
                sel_b  = b_in[i*DATA_WIDTH +: DATA_WIDTH];
                sel_op = op_in[i];
            end
        end
    end

    always_comb begin
        state_next = state;
        grant_next = '0;
        done_next  = '0;
        load       = 1'b0;
        capture    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (found) begin
                    load       = 1'b1;
                    grant_next = onehot(win);
                    state_next = EXEC;
                end else begin
                    state_next = IDLE;
                end
            end
            EXEC: begin
                // last_idx already holds the winner loaded on the grant edge
                capture    = 1'b1;
                done_next  = onehot(last_idx);
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_idx   <= IDX_WIDTH'(NUM_REQ - 1);
            grant_out  <= '0;
            done_out   <= '0;
            result_out <= '0;
            alu_a_out  <= '0;
            alu_b_out  <= '0;
            alu_op_out <= 1'b0;
        end else begin
            grant_out <= grant_next;
            done_out  <= done_next;
            if (load) begin
                last_idx   <= win;
                alu_a_out  <= sel_a;
                alu_b_out  <= sel_b;
                alu_op_out <= sel_op;
            end
            if (capture) begin
                result_out <= alu_result_in;
            end
        end
    end

    assign busy_out = (state != IDLE);

endmodule
